// File: rtl/eth_phy_10g_rx_link_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared types and constants for the 10G PHY RX link controller:
//   - link_state_t : link bring-up state encoding
//   - RETRY_CNT_W  : width of the saturating SERDES retry counter
//   - ERR_CNT_W    : width of the saturating bad-block counter
//   - max4()       : constant helper used to size the shared timer
// No ports (package).
// ---------------------------------------------------------------------------
package eth_phy_10g_pkg;

  localparam int RETRY_CNT_W = 8;
  localparam int ERR_CNT_W   = 16;

  typedef enum logic [2:0] {
    RST_SERDES = 3'd0,
    WAIT_DONE  = 3'd1,
    WAIT_LOCK  = 3'd2,
    QUALIFY    = 3'd3,
    UP         = 3'd4
  } link_state_t;

  // Largest of four values, used at elaboration time for timer sizing.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_link_ctrl_if.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_link_ctrl_if
// Bundle of the status/control signals between the RX link controller and
// the SERDES / PCS / BER blocks around it.
//   master : the link controller (drives reset requests and link status)
//   slave  : the PHY side (drives reset-done, lock, BER and bad-block flags)
// Signals:
//   serdes_rx_reset_done  PHY->ctrl  SERDES RX reset sequence complete (level)
//   rx_block_lock         PHY->ctrl  block lock from RX frame sync
//   rx_high_ber           PHY->ctrl  high-BER flag
//   rx_bad_block          PHY->ctrl  one-cycle pulse per bad decoded block
//   serdes_rx_reset       ctrl->PHY  SERDES RX reset request
//   pcs_rx_reset          ctrl->PHY  holds frame sync / decoder in reset
//   rx_status             ctrl->PHY  link up
//   rx_retry_count[7:0]   ctrl->PHY  SERDES reset retries, saturating
// Optional (macro ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN):
//   err_cnt_clr           PHY->ctrl  clear bad-block counter
//   rx_bad_block_count    ctrl->PHY  bad blocks seen while up, saturating
// ---------------------------------------------------------------------------
interface eth_phy_10g_rx_link_ctrl_if;
  import eth_phy_10g_pkg::*;

  logic                   serdes_rx_reset_done;
  logic                   rx_block_lock;
  logic                   rx_high_ber;
  logic                   rx_bad_block;
  logic                   serdes_rx_reset;
  logic                   pcs_rx_reset;
  logic                   rx_status;
  logic [RETRY_CNT_W-1:0] rx_retry_count;
`ifdef ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN
  logic                   err_cnt_clr;
  logic [ERR_CNT_W-1:0]   rx_bad_block_count;

  modport master (
    input  serdes_rx_reset_done, rx_block_lock, rx_high_ber, rx_bad_block, err_cnt_clr,
    output serdes_rx_reset, pcs_rx_reset, rx_status, rx_retry_count, rx_bad_block_count
  );
  modport slave (
    output serdes_rx_reset_done, rx_block_lock, rx_high_ber, rx_bad_block, err_cnt_clr,
    input  serdes_rx_reset, pcs_rx_reset, rx_status, rx_retry_count, rx_bad_block_count
  );
`else
  modport master (
    input  serdes_rx_reset_done, rx_block_lock, rx_high_ber, rx_bad_block,
    output serdes_rx_reset, pcs_rx_reset, rx_status, rx_retry_count
  );
  modport slave (
    output serdes_rx_reset_done, rx_block_lock, rx_high_ber, rx_bad_block,
    input  serdes_rx_reset, pcs_rx_reset, rx_status, rx_retry_count
  );
`endif

endinterface

// File: rtl/eth_sat_counter.sv
// ---------------------------------------------------------------------------
// eth_sat_counter
// Registered up-counter that saturates at all-ones instead of wrapping.
// A clear in the same cycle as an increment yields 1, so the event that
// coincides with the clear is not lost.
// Ports:
//   clk    input        clock
//   rst    input        synchronous active-high reset (count -> 0)
//   inc    input        increment request
//   clr    input        synchronous clear
//   count  output [W]   current count (register)
// ---------------------------------------------------------------------------
module eth_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  // Saturating count register with clear-wins-but-keeps-coincident-event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (clr) begin
      r_count <= inc ? WIDTH'(1) : {WIDTH{1'b0}};
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_link_ctrl
// RX link bring-up controller for a 10GBASE-R PHY. Pulses the SERDES RX
// reset, waits for the SERDES to report reset done, releases the PCS,
// waits for block lock without high BER, qualifies the link for
// STABLE_CYCLES consecutive good cycles and then reports link up. Loss of
// SERDES reset-done or a wait timeout restarts the sequence and bumps a
// saturating retry counter; loss of lock/high BER only falls back to
// waiting for lock.
// Parameters:
//   SERDES_RST_CYCLES    serdes_rx_reset pulse length (>=1)
//   DONE_TIMEOUT_CYCLES  max wait for serdes_rx_reset_done
//   LOCK_TIMEOUT_CYCLES  max wait for block lock after PCS release
//   STABLE_CYCLES        consecutive good cycles needed before link up
// Ports:
//   clk   input   clock, rising edge
//   rst   input   synchronous active-high reset
//   bus   master  link control/status bundle (see eth_phy_10g_rx_link_ctrl_if)
// Optional bad-block counter: define ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN.
// ---------------------------------------------------------------------------
module eth_phy_10g_rx_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int SERDES_RST_CYCLES   = 64,
  parameter int DONE_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int STABLE_CYCLES       = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  eth_phy_10g_rx_link_ctrl_if.master bus
);

  localparam int TIMER_MAX = max4(SERDES_RST_CYCLES, DONE_TIMEOUT_CYCLES,
                                  LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  // Terminal timer values: the timer holds "cycles already spent" in the
  // current state, so the last cycle of an N-cycle window has timer N-1.
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(SERDES_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST   = TIMER_W'(DONE_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};

  link_state_t            r_state;
  link_state_t            w_next_state;
  logic [TIMER_W-1:0]     r_timer;
  logic [TIMER_W-1:0]     w_timer_nxt;
  logic                   w_retry_inc;
  logic                   w_good;
  logic                   w_done;

  logic                   r_serdes_rx_reset;
  logic                   r_pcs_rx_reset;
  logic                   r_rx_status;
  logic                   w_serdes_rx_reset_nxt;
  logic                   w_pcs_rx_reset_nxt;
  logic                   w_rx_status_nxt;
  logic [RETRY_CNT_W-1:0] w_retry_count;

  assign w_done = bus.serdes_rx_reset_done;
  assign w_good = bus.rx_block_lock & ~bus.rx_high_ber;

  // State and shared timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_SERDES;
      r_timer <= TIMER_ZERO;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state, timer and retry-event logic.
  // Within each state the checks are ordered reset-done loss, then timeout,
  // then lock/BER, which gives the required exit priority.
  always_comb begin
    w_next_state = r_state;
    w_timer_nxt  = r_timer + TIMER_W'(1);
    w_retry_inc  = 1'b0;
    case (r_state)
      RST_SERDES: begin
        if (r_timer == RST_LAST) begin
          w_next_state = WAIT_DONE;
          w_timer_nxt  = TIMER_ZERO;
        end else begin
          w_next_state = RST_SERDES;
        end
      end
      WAIT_DONE: begin
        if (w_done) begin
          w_next_state = WAIT_LOCK;
          w_timer_nxt  = TIMER_ZERO;
        end else if (r_timer == DONE_LAST) begin
          w_next_state = RST_SERDES;
          w_timer_nxt  = TIMER_ZERO;
          w_retry_inc  = 1'b1;
        end else begin
          w_next_state = WAIT_DONE;
        end
      end
      WAIT_LOCK: begin
        if (!w_done || (r_timer == LOCK_LAST)) begin
          w_next_state = RST_SERDES;
          w_timer_nxt  = TIMER_ZERO;
          w_retry_inc  = 1'b1;
        end else if (w_good) begin
          w_next_state = QUALIFY;
          w_timer_nxt  = TIMER_ZERO;
        end else begin
          w_next_state = WAIT_LOCK;
        end
      end
      QUALIFY: begin
        // Any bad cycle restarts the lock wait with a fresh timeout window.
        if (!w_done) begin
          w_next_state = RST_SERDES;
          w_timer_nxt  = TIMER_ZERO;
          w_retry_inc  = 1'b1;
        end else if (!w_good) begin
          w_next_state = WAIT_LOCK;
          w_timer_nxt  = TIMER_ZERO;
        end else if (r_timer == STABLE_LAST) begin
          w_next_state = UP;
          w_timer_nxt  = TIMER_ZERO;
        end else begin
          w_next_state = QUALIFY;
        end
      end
      UP: begin
        w_timer_nxt = TIMER_ZERO;
        if (!w_done) begin
          w_next_state = RST_SERDES;
          w_retry_inc  = 1'b1;
        end else if (!w_good) begin
          w_next_state = WAIT_LOCK;
        end else begin
          w_next_state = UP;
        end
      end
      default: begin
        w_next_state = RST_SERDES;
        w_timer_nxt  = TIMER_ZERO;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state register.
  always_comb begin
    w_serdes_rx_reset_nxt = (w_next_state == RST_SERDES);
    w_pcs_rx_reset_nxt    = (w_next_state == RST_SERDES) || (w_next_state == WAIT_DONE);
    w_rx_status_nxt       = (w_next_state == UP);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_serdes_rx_reset <= 1'b1;
      r_pcs_rx_reset    <= 1'b1;
      r_rx_status       <= 1'b0;
    end else begin
      r_serdes_rx_reset <= w_serdes_rx_reset_nxt;
      r_pcs_rx_reset    <= w_pcs_rx_reset_nxt;
      r_rx_status       <= w_rx_status_nxt;
    end
  end

  eth_sat_counter #(
    .WIDTH (RETRY_CNT_W)
  ) u_retry_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_retry_inc),
    .clr   (1'b0),
    .count (w_retry_count)
  );

  assign bus.serdes_rx_reset = r_serdes_rx_reset;
  assign bus.pcs_rx_reset    = r_pcs_rx_reset;
  assign bus.rx_status       = r_rx_status;
  assign bus.rx_retry_count  = w_retry_count;

`ifdef ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN
  logic                 w_bad_inc;
  logic [ERR_CNT_W-1:0] w_bad_count;

  // Only bad blocks seen while the link is up are meaningful errors.
  assign w_bad_inc = bus.rx_bad_block & (r_state == UP);

  eth_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_bad_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bad_inc),
    .clr   (bus.err_cnt_clr),
    .count (w_bad_count)
  );

  assign bus.rx_bad_block_count = w_bad_count;
`else
  logic w_unused_bad_block;
  assign w_unused_bad_block = bus.rx_bad_block;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
module tb_eth_phy_10g_rx_link_ctrl;

  localparam int P_RST    = 4;
  localparam int P_DONE   = 16;
  localparam int P_LOCK   = 100;
  localparam int P_STABLE = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  eth_phy_10g_rx_link_ctrl_if lnk_if ();

  eth_phy_10g_rx_link_ctrl #(
    .SERDES_RST_CYCLES   (P_RST),
    .DONE_TIMEOUT_CYCLES (P_DONE),
    .LOCK_TIMEOUT_CYCLES (P_LOCK),
    .STABLE_CYCLES       (P_STABLE)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (lnk_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Link bring-up described as phases with "cycles spent in phase" and the
  // exit rules applied in priority order.
  localparam int PH_PULSE = 0, PH_AWAIT_DONE = 1, PH_AWAIT_LOCK = 2, PH_QUAL = 3, PH_LINK = 4;
  int m_phase, m_spent, m_retry, m_bad;

  task automatic model_reset();
    m_phase = PH_PULSE; m_spent = 0; m_retry = 0; m_bad = 0;
  endtask

  task automatic model_step(input bit r, input bit d, input bit l, input bit h,
                            input bit b, input bit c);
    bit good;
    int nxt;
    bit retry_ev;
    if (r) begin
      model_reset();
      return;
    end
    good = l && !h;
    if (c) m_bad = (m_phase == PH_LINK && b) ? 1 : 0;
    else if (m_phase == PH_LINK && b && m_bad < 65535) m_bad = m_bad + 1;
    m_spent = m_spent + 1;
    nxt = m_phase;
    retry_ev = 1'b0;
    if (m_phase == PH_PULSE) begin
      if (m_spent == P_RST) nxt = PH_AWAIT_DONE;
    end else if (m_phase == PH_AWAIT_DONE) begin
      if (d) nxt = PH_AWAIT_LOCK;
      else if (m_spent == P_DONE) retry_ev = 1'b1;
    end else begin
      if (!d) retry_ev = 1'b1;
      else if (m_phase == PH_AWAIT_LOCK && m_spent == P_LOCK) retry_ev = 1'b1;
      else if (m_phase == PH_AWAIT_LOCK && good) nxt = PH_QUAL;
      else if (m_phase != PH_AWAIT_LOCK && !good) nxt = PH_AWAIT_LOCK;
      else if (m_phase == PH_QUAL && m_spent == P_STABLE) nxt = PH_LINK;
    end
    if (retry_ev) begin
      nxt = PH_PULSE;
      if (m_retry < 255) m_retry = m_retry + 1;
    end
    if (nxt != m_phase) m_spent = 0;
    m_phase = nxt;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s act=%0d exp=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit d, input bit l, input bit h, input bit b, input bit c);
    lnk_if.serdes_rx_reset_done = d;
    lnk_if.rx_block_lock        = l;
    lnk_if.rx_high_ber          = h;
    lnk_if.rx_bad_block         = b;
`ifdef ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN
    lnk_if.err_cnt_clr          = c;
`else
    if (c) begin end
`endif
  endtask

  // Applies reset, checks the reset state and releases reset at a falling
  // edge; the caller is then in cycle 0 of the bring-up sequence.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_serdes_rx_reset", int'(lnk_if.serdes_rx_reset), 1);
    check("rst_pcs_rx_reset", int'(lnk_if.pcs_rx_reset), 1);
    check("rst_rx_status", int'(lnk_if.rx_status), 0);
    check("rst_retry", int'(lnk_if.rx_retry_count), 0);
`ifdef ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN
    check("rst_bad_count", int'(lnk_if.rx_bad_block_count), 0);
`endif
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int cyc;
    bit serdes;
    bit pcs;
    bit status;
    int retry;
  } chk_t;

  chk_t tbl[10];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Normal bring-up: done from cycle 6, lock from cycle 10.
    tbl[0] = '{0,  1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{3,  1'b1, 1'b1, 1'b0, 0};
    tbl[2] = '{4,  1'b0, 1'b1, 1'b0, 0};
    tbl[3] = '{6,  1'b0, 1'b1, 1'b0, 0};
    tbl[4] = '{7,  1'b0, 1'b0, 1'b0, 0};
    tbl[5] = '{10, 1'b0, 1'b0, 1'b0, 0};
    tbl[6] = '{11, 1'b0, 1'b0, 1'b0, 0};
    tbl[7] = '{18, 1'b0, 1'b0, 1'b0, 0};
    tbl[8] = '{19, 1'b0, 1'b0, 1'b1, 0};
    tbl[9] = '{22, 1'b0, 1'b0, 1'b1, 0};

    do_reset();
    for (int k = 0; k < 24; k++) begin
      if (k != 0) @(negedge clk);
      for (int j = 0; j < 10; j++) begin
        if (tbl[j].cyc == k) begin
          check($sformatf("up_serdes_c%0d", k), int'(lnk_if.serdes_rx_reset), int'(tbl[j].serdes));
          check($sformatf("up_pcs_c%0d", k), int'(lnk_if.pcs_rx_reset), int'(tbl[j].pcs));
          check($sformatf("up_status_c%0d", k), int'(lnk_if.rx_status), int'(tbl[j].status));
          check($sformatf("up_retry_c%0d", k), int'(lnk_if.rx_retry_count), tbl[j].retry);
        end
      end
      drive(k >= 6, k >= 10, 1'b0, 1'b0, 1'b0);
    end

    // Done never arrives: 20-cycle retry period, retry saturates at 255.
    do_reset();
    for (int k = 0; k < 260 * 20; k++) begin
      if (k != 0) @(negedge clk);
      if (k % 20 == 0) begin
        check("to_serdes_hi", int'(lnk_if.serdes_rx_reset), 1);
        check("to_retry", int'(lnk_if.rx_retry_count), (k / 20 > 255) ? 255 : k / 20);
      end
      if (k % 20 == 3) check("to_serdes_last_hi", int'(lnk_if.serdes_rx_reset), 1);
      if (k % 20 == 4) check("to_serdes_lo", int'(lnk_if.serdes_rx_reset), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Done present, lock never: lock timeout after 100 cycles.
    do_reset();
    for (int k = 0; k < 107; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 104) begin
        check("lto_serdes_before", int'(lnk_if.serdes_rx_reset), 0);
        check("lto_pcs_before", int'(lnk_if.pcs_rx_reset), 0);
        check("lto_retry_before", int'(lnk_if.rx_retry_count), 0);
      end
      if (k == 105) begin
        check("lto_serdes_after", int'(lnk_if.serdes_rx_reset), 1);
        check("lto_pcs_after", int'(lnk_if.pcs_rx_reset), 1);
        check("lto_retry_after", int'(lnk_if.rx_retry_count), 1);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Lock drop during qualify, then high BER while up.
    do_reset();
    for (int k = 0; k < 36; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 11 || k == 14 || k == 20 || k == 32)
        check($sformatf("q_status_lo_c%0d", k), int'(lnk_if.rx_status), 0);
      if (k == 21 || k == 23 || k == 33)
        check($sformatf("q_status_hi_c%0d", k), int'(lnk_if.rx_status), 1);
      if (k == 24) begin
        check("ber_status_lo", int'(lnk_if.rx_status), 0);
        check("ber_retry", int'(lnk_if.rx_retry_count), 0);
      end
      drive(1'b1, (k >= 5) && (k != 11), k == 23, 1'b0, 1'b0);
    end

`ifdef ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN
    // Bad-block counting only in UP, clear with coincident pulse gives 1.
    do_reset();
    for (int k = 0; k < 26; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 14) begin
        check("bb_status_up", int'(lnk_if.rx_status), 1);
        check("bb_ignored", int'(lnk_if.rx_bad_block_count), 0);
      end
      if (k == 20) check("bb_three", int'(lnk_if.rx_bad_block_count), 3);
      if (k == 22) check("bb_clr_pulse", int'(lnk_if.rx_bad_block_count), 1);
      if (k == 24) check("bb_clr", int'(lnk_if.rx_bad_block_count), 0);
      drive(1'b1, 1'b1, 1'b0,
            (k == 8) || (k == 15) || (k == 17) || (k == 19) || (k == 21),
            (k == 21) || (k == 23));
    end
`endif

    // Randomized stimulus against the reference model.
    do_reset();
    begin
      int mode;
      bit d, l, h, b, c, r;
      mode = 0;
      for (int i = 0; i < 4000; i++) begin
        if (i != 0) @(negedge clk);
        check("rnd_serdes", int'(lnk_if.serdes_rx_reset), (m_phase == PH_PULSE) ? 1 : 0);
        check("rnd_pcs", int'(lnk_if.pcs_rx_reset), (m_phase <= PH_AWAIT_DONE) ? 1 : 0);
        check("rnd_status", int'(lnk_if.rx_status), (m_phase == PH_LINK) ? 1 : 0);
        check("rnd_retry", int'(lnk_if.rx_retry_count), m_retry);
`ifdef ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN
        check("rnd_bad_count", int'(lnk_if.rx_bad_block_count), m_bad);
`endif
        if (i % 64 == 0) mode = int'($urandom_range(0, 3));
        case (mode)
          0: begin d = 1'b1; l = ($urandom_range(0, 99) < 98); h = ($urandom_range(0, 99) < 1); end
          1: begin d = ($urandom_range(0, 99) < 97); l = ($urandom_range(0, 99) < 90); h = 1'b0; end
          2: begin d = ($urandom_range(0, 99) < 10); l = ($urandom_range(0, 1) == 1); h = 1'b0; end
          default: begin d = 1'b1; l = ($urandom_range(0, 99) < 5); h = ($urandom_range(0, 99) < 20); end
        endcase
        b = ($urandom_range(0, 99) < 15);
        c = ($urandom_range(0, 99) < 3);
        r = ($urandom_range(0, 399) == 0);
        rst = r;
        drive(d, l, h, b, c);
        model_step(r, d, l, h, b, c);
      end
      @(negedge clk);
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_rx_link_ctrl.md
ETH_PHY_10G_RX_LINK_CTRL -- requirements
Module: eth_phy_10g_rx_link_ctrl

Interface
REQ-001 SHALL have parameter SERDES_RST_CYCLES, default 64, serdes_rx_reset pulse length in clk cycles (>=1).
REQ-002 SHALL have parameter DONE_TIMEOUT_CYCLES, default 4096, max wait for serdes_rx_reset_done.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 125000, max wait for block lock after PCS release.
REQ-004 SHALL have parameter STABLE_CYCLES, default 1024, consecutive good cycles required before link up.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port serdes_rx_reset_done  input  1  SERDES RX reset sequence complete (level).
REQ-008 SHALL have port rx_block_lock  input  1  block lock from RX frame sync.
REQ-009 SHALL have port rx_high_ber  input  1  high-BER flag from BER monitor.
REQ-010 SHALL have port rx_bad_block  input  1  one-cycle pulse per bad decoded block.
REQ-011 SHALL have port serdes_rx_reset  output  1  SERDES RX reset request.
REQ-012 SHALL have port pcs_rx_reset  output  1  holds frame sync/decoder in reset.
REQ-013 SHALL have port rx_status  output  1  link up.
REQ-014 SHALL have port rx_retry_count  output  8  SERDES reset retries, saturating.
REQ-015 SHALL have ports err_cnt_clr input 1 and rx_bad_block_count output 16 only when the macro of REQ-031 is defined.

Function
REQ-016 SHALL implement states RST_SERDES, WAIT_DONE, WAIT_LOCK, QUALIFY, UP with one shared down/up timer sized $clog2(max parameter + 1).
REQ-017 RST_SERDES: serdes_rx_reset=1, pcs_rx_reset=1 for exactly SERDES_RST_CYCLES cycles, then WAIT_DONE.
REQ-018 WAIT_DONE: serdes_rx_reset=0, pcs_rx_reset=1; serdes_rx_reset_done=1 -> WAIT_LOCK next cycle; DONE_TIMEOUT_CYCLES elapsed without done -> RST_SERDES, retry++.
REQ-019 WAIT_LOCK: pcs_rx_reset=0; rx_block_lock=1 and rx_high_ber=0 -> QUALIFY; LOCK_TIMEOUT_CYCLES elapsed -> RST_SERDES, retry++.
REQ-020 QUALIFY: timer counts consecutive cycles with lock=1, high_ber=0; reaching STABLE_CYCLES -> UP; any bad cycle -> WAIT_LOCK with lock timer restarted.
REQ-021 UP: rx_status=1; rx_block_lock=0 or rx_high_ber=1 -> WAIT_LOCK (rx_status=0 from next cycle), no retry increment.
REQ-022 serdes_rx_reset_done falling in WAIT_LOCK, QUALIFY or UP -> RST_SERDES, retry++.
REQ-023 rx_status SHALL be registered, asserted only in UP; it deasserts the cycle after leaving UP.
REQ-024 rx_retry_count SHALL saturate at 255, never wrap; cleared only by rst.
REQ-025 When multiple exit conditions hold in one cycle, priority: reset_done loss > timeout > lock/BER condition.

Reset
REQ-026 On rst: state RST_SERDES, timer 0, serdes_rx_reset=1, pcs_rx_reset=1, rx_status=0, rx_retry_count=0, rx_bad_block_count=0.
REQ-027 rst mid-sequence SHALL abort and restart a full SERDES_RST_CYCLES pulse after release; retry count not incremented.
REQ-028 All outputs SHALL be driven directly from registers.

Configuration
REQ-029 Without macro, REQ-015 ports and counter logic SHALL be absent.
REQ-030 With macro, rx_bad_block_count increments per rx_bad_block only in UP, saturates at 65535; err_cnt_clr clears it; clear and pulse same cycle -> 1.
REQ-031 Macro name SHALL be ETH_PHY_10G_RX_LINK_CTRL_ERR_CNT_EN.

Structure
REQ-032 State enum and retry/err counter width constants SHALL live in package eth_phy_10g_pkg.
REQ-033 Saturating counters SHALL use one sub-module eth_sat_counter (params WIDTH; inputs inc, clr; output count).

Verification (SERDES_RST_CYCLES=4, DONE_TIMEOUT_CYCLES=16, LOCK_TIMEOUT_CYCLES=100, STABLE_CYCLES=8)
REQ-034 Release rst, done=1 at cycle 6, lock=1 at 10 -> serdes_rx_reset high exactly 4 cycles, rx_status=1 after 8 stable cycles, retry=0.
REQ-035 done held 0 -> serdes_rx_reset re-pulses every 4+16 cycles; retry increments per timeout, stops at 255 after 256 timeouts.
REQ-036 done=1, lock never -> RST_SERDES after 100 cycles in WAIT_LOCK, retry=1.
REQ-037 In QUALIFY, lock drops at good-cycle 5 -> back to WAIT_LOCK, rx_status stays 0; in UP, high_ber=1 -> rx_status=0 next cycle, retry unchanged.
REQ-038 Macro on: 3 bad pulses in UP -> count 3; clr with simultaneous pulse -> 1; pulses outside UP ignored.
